// File: rtl/gb_cpu_common_pkg.sv
// Shared CPU types and opcode constants used by the fetch unit and decoder.
package gb_cpu_common_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_FETCH_CB = 3'd2,
        ST_VALID    = 3'd3,
        ST_HALT     = 3'd4
    } fetch_state_t;

    localparam logic [7:0] CB_PREFIX_OPC = 8'hCB;
    localparam logic [7:0] ISR_NOP_OPC   = 8'h00;

endpackage

// File: rtl/gb_cpu_fetch.sv
// Instruction fetch FSM: reads opcode bytes (with optional 0xCB prefix),
// injects interrupt dispatch slots and implements HALT wake-up.
module gb_cpu_fetch
    import gb_cpu_common_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic        halt_req,
    input  logic [15:0] pc,
    input  logic        ime,
    input  logic        int_pending,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic        pc_inc,
    output logic [7:0]  opcode,
    output logic        cb_prefix,
    output logic        isr_cmd,
    output logic        instr_valid,
    input  logic        instr_ack,
    output logic        halted
);

    fetch_state_t r_state;
    logic [15:0]  r_fetch_addr;
    logic [7:0]   r_opcode;
    logic         r_cb_prefix;
    logic         r_isr_cmd;
    logic         r_pc_inc_d;
    logic [15:0]  w_cb_addr;
    logic         w_accept;

    assign w_cb_addr = r_fetch_addr + 16'd1;

    // A back-to-back ready on the prefix byte is held off one cycle so the
    // register file never sees two adjacent increments.
    assign w_accept = mem_ready &&
                      ((r_state == ST_FETCH) ||
                       ((r_state == ST_FETCH_CB) && !r_pc_inc_d));

    always_comb begin
        mem_rd   = 1'b0;
        mem_addr = 16'h0000;
        case (r_state)
            ST_FETCH: begin
                mem_rd   = 1'b1;
                mem_addr = r_fetch_addr;
            end
            ST_FETCH_CB: begin
                mem_rd   = 1'b1;
                mem_addr = w_cb_addr;
            end
            default: ;
        endcase
    end

    assign pc_inc      = w_accept;
    assign opcode      = r_opcode;
    assign cb_prefix   = r_cb_prefix;
    assign isr_cmd     = r_isr_cmd;
    assign instr_valid = (r_state == ST_VALID);
    assign halted      = (r_state == ST_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_fetch_addr <= 16'h0000;
            r_opcode     <= 8'h00;
            r_cb_prefix  <= 1'b0;
            r_isr_cmd    <= 1'b0;
            r_pc_inc_d   <= 1'b0;
        end else begin
            r_pc_inc_d <= w_accept;
            case (r_state)
                ST_IDLE: begin
                    if (halt_req) begin
                        r_state <= ST_HALT;
                    end else if (fetch_req) begin
                        if (ime && int_pending) begin
                            r_state     <= ST_VALID;
                            r_opcode    <= ISR_NOP_OPC;
                            r_cb_prefix <= 1'b0;
                            r_isr_cmd   <= 1'b1;
                        end else begin
                            r_state      <= ST_FETCH;
                            r_fetch_addr <= pc;
                        end
                    end
                end
                ST_FETCH: begin
                    if (w_accept) begin
                        r_isr_cmd <= 1'b0;
                        if (mem_rdata == CB_PREFIX_OPC) begin
                            r_state     <= ST_FETCH_CB;
                            r_cb_prefix <= 1'b1;
                        end else begin
                            r_state     <= ST_VALID;
                            r_opcode    <= mem_rdata;
                            r_cb_prefix <= 1'b0;
                        end
                    end
                end
                ST_FETCH_CB: begin
                    // Second byte is always an opcode, even if it is 0xCB again.
                    if (w_accept) begin
                        r_state  <= ST_VALID;
                        r_opcode <= mem_rdata;
                    end
                end
                ST_VALID: begin
                    if (instr_ack) r_state <= ST_IDLE;
                end
                ST_HALT: begin
                    if (int_pending) begin
                        if (ime) begin
                            r_state     <= ST_VALID;
                            r_opcode    <= ISR_NOP_OPC;
                            r_cb_prefix <= 1'b0;
                            r_isr_cmd   <= 1'b1;
                        end else begin
                            r_state      <= ST_FETCH;
                            r_fetch_addr <= pc;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/gb_cpu_fetch.md
GB_CPU_FETCH -- requirements
Module: gb_cpu_fetch

Interface
REQ-001 clk  input  1  CPU clock; one clock is one fetch-FSM step.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 fetch_req  input  1  sequencer request for the next instruction; sampled only in IDLE.
REQ-004 halt_req  input  1  enter low-power wait; sampled only in IDLE.
REQ-005 pc  input  16  current program counter, owned by the register file.
REQ-006 ime  input  1  interrupt master enable.
REQ-007 int_pending  input  1  high when (IE & IF) is non-zero.
REQ-008 mem_rd  output  1  bus read strobe.
REQ-009 mem_addr  output  16  bus read address.
REQ-010 mem_rdata  input  8  bus read data, valid when mem_ready=1.
REQ-011 mem_ready  input  1  read-completion qualifier.
REQ-012 pc_inc  output  1  one-cycle pulse; the register file increments PC by 1.
REQ-013 opcode  output  8  instruction byte for the decoder.
REQ-014 cb_prefix  output  1  opcode was preceded by 0xCB.
REQ-015 isr_cmd  output  1  slot carries the interrupt dispatch, not a fetched opcode.
REQ-016 instr_valid  output  1  opcode, cb_prefix and isr_cmd are stable and decodable.
REQ-017 instr_ack  input  1  sequencer has consumed the presented instruction.
REQ-018 halted  output  1  FSM is in HALT.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, FETCH_CB, VALID and HALT.
REQ-020 IDLE, halt_req=1: go to HALT; halt_req wins over a simultaneous fetch_req.
REQ-021 IDLE, fetch_req=1, ime=1 and int_pending=1: go to VALID next cycle.
  - isr_cmd=1, opcode=0x00, cb_prefix=0.
  - No bus read, no pc_inc.
REQ-022 IDLE, fetch_req=1 otherwise: go to FETCH; latch pc into fetch_addr.
REQ-023 FETCH: mem_rd=1, mem_addr=fetch_addr; the FSM holds until mem_ready=1 (unbounded wait states).
REQ-024 FETCH with mem_ready=1:
  - Pulse pc_inc for exactly that cycle.
  - mem_rdata=0xCB: go to FETCH_CB with cb_prefix=1.
  - Otherwise: latch opcode=mem_rdata, go to VALID.
REQ-025 FETCH_CB: mem_rd=1, mem_addr=fetch_addr+1 (16-bit modulo, 0xFFFF wraps to 0x0000).
  - On mem_ready=1: pulse pc_inc, latch opcode, go to VALID.
REQ-026 In FETCH_CB a second 0xCB byte SHALL be treated as an ordinary CB opcode; no further prefix is chained.
REQ-027 VALID: instr_valid=1 and outputs held stable.
  - instr_ack=1: go to IDLE next cycle.
  - instr_ack=1 together with fetch_req=1 in the same cycle is legal; the new request is honoured in the following IDLE cycle.
REQ-028 HALT: halted=1, mem_rd=0.
  - int_pending=1 and ime=1: go to VALID with isr_cmd=1.
  - int_pending=1 and ime=0: go to FETCH (fetch_addr=pc), without duplicating the next byte.
REQ-029 mem_rd SHALL be 1 only in FETCH and FETCH_CB; mem_addr SHALL be 0x0000 elsewhere.
REQ-030 pc_inc SHALL never assert in two consecutive cycles.
REQ-031 instr_ack outside VALID SHALL be ignored.

Reset
REQ-032 Reset SHALL act immediately, including mid-fetch, and asynchronously force:
  - FSM to IDLE.
  - opcode=0x00; cb_prefix, isr_cmd, instr_valid, mem_rd, pc_inc and halted all 0.
  - mem_addr=0x0000, fetch_addr=0x0000.
REQ-033 After rst_n deasserts, the first fetch SHALL occur only on fetch_req; no read is issued spontaneously.

Structure
REQ-034 fetch_state_t (enum of the five states) and the constants CB_PREFIX_OPC=8'hCB and ISR_NOP_OPC=8'h00 SHALL live in gb_cpu_common_pkg.
REQ-035 The block SHALL be a single module with no sub-modules; its outputs connect directly to the gb_cpu_decoder inputs opcode, cb_prefix and isr_cmd.

Verification
REQ-036 Plain fetch:
  - pc=0x0100, fetch_req, mem_rdata=0x3E, mem_ready after 2 wait cycles.
  - Expect mem_addr=0x0100, one pc_inc, then VALID with opcode=0x3E, cb_prefix=0.
REQ-037 CB prefix at wrap:
  - pc=0xFFFF, reads 0xCB then 0x7C.
  - Expect second read at 0x0000, two pc_inc pulses, opcode=0x7C, cb_prefix=1.
REQ-038 Interrupt dispatch:
  - ime=1, int_pending=1, fetch_req.
  - Expect VALID with isr_cmd=1, opcode=0x00, mem_rd never 1, no pc_inc.
REQ-039 HALT, both wake paths:
  - halt_req and fetch_req together: enter HALT with halted=1.
  - Raise int_pending with ime=0: expect a fetch at the current pc.
  - Repeat with ime=1: expect isr_cmd=1.
REQ-040 Reset mid-read:
  - Assert rst_n=0 during FETCH with mem_ready=0.
  - Expect mem_rd=0 and instr_valid=0 immediately.
  - After release: no read until fetch_req.
REQ-041 Back-to-back:
  - instr_ack and fetch_req in the same cycle.
  - Expect exactly one IDLE cycle, then FETCH; opcode holds its value until the new read completes.
